// File: rtl/regfile_dump.sv
// regfile_dump: walks a programmable range of register-file addresses through
// one read port and streams each captured value with its address over a
// valid/ready interface. READ and SEND alternate, so peak rate is one word
// every two cycles.
module regfile_dump #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0] data_readReg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    // Next-state and datapath capture; abort outranks every other transition
    // once the engine has left IDLE.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d = first_reg;
                    end_addr_d = last_reg;
                    state_d    = READ;
                end
            end
            READ: begin
                if (abort) begin
                    out_last_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    out_data_d = data_readReg;
                    out_addr_d = cur_addr_q;
                    out_last_d = (cur_addr_q == end_addr_q);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    out_last_d = 1'b0;
                    state_d    = IDLE;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the wrap through the top register.
                        cur_addr_d = cur_addr_q + ADDR_ONE;
                        state_d    = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    // Stream flags decode straight from the state register, so an asynchronous
    // reset drops out_valid without waiting for an edge.
    always_comb begin
        ctrl_readReg = cur_addr_q;
        out_valid    = (state_q == SEND);
        out_data     = out_data_q;
        out_addr     = out_addr_q;
        out_last     = out_last_q;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed testbench for regfile_dump: full dump, wrap-around, backpressure,
// abort, start-while-busy and asynchronous reset.
module tb_regfile_dump;

    logic        clock;
    logic        ctrl_reset_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs_m [32];

    int unsigned checks;
    int unsigned errors;

    regfile_dump #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .start        (start),
        .abort        (abort),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    // Register-file model: combinational read port.
    assign data_readReg = regs_m[ctrl_readReg];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_readreg"}, 32'(ctrl_readReg), 32'd0);
        check({tag, "_valid"},   32'(out_valid),    32'd0);
        check({tag, "_data"},    out_data,          32'd0);
        check({tag, "_addr"},    32'(out_addr),     32'd0);
        check({tag, "_last"},    32'(out_last),     32'd0);
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_done"},    32'(done),         32'd0);
    endtask

    // Runs one dump with out_ready high, checking every word, the final
    // done pulse and busy falling. poke pulses start with first_reg = 0
    // right after the first word is accepted.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit poke);
        logic [4:0]  diff;
        logic [4:0]  exp_a;
        int unsigned n;
        int unsigned got;
        int unsigned budget;
        int unsigned dones;
        diff      = l - f;
        n         = int'(diff) + 1;
        got       = 0;
        budget    = 0;
        dones     = 0;
        out_ready = 1'b1;
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (got < n && budget < 400) begin
            if (out_valid && out_ready) begin
                exp_a = f + 5'(got);
                check("word_addr", 32'(out_addr), 32'(exp_a));
                check("word_data", out_data, regs_m[exp_a]);
                check("word_last", 32'(out_last), 32'(got == n - 1));
                got++;
                if (poke && got == 1) begin
                    start     = 1'b1;
                    first_reg = 5'd0;
                end
            end
            if (done) dones++;
            @(negedge clock);
            start = 1'b0;
            budget++;
        end
        check("word_count", got, n);
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        if (done) dones++;
        @(negedge clock);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
        check("done_count", dones, 32'd1);
    endtask

    initial begin
        int unsigned budget;
        int unsigned dones;
        checks       = 0;
        errors       = 0;
        ctrl_reset_n = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        first_reg    = '0;
        last_reg     = '0;
        out_ready    = 1'b0;
        for (int k = 0; k < 32; k++) regs_m[k] = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("idle");

        // Full dump 0..31, spot-check hand constants on regs model.
        check("reg0_model", regs_m[0], 32'h0000_0000);
        check("reg31_model", regs_m[31], 32'h1000_001F);
        run_dump(5'd0, 5'd31, 1'b0);

        // Wrap-around 30..1: 30, 31, 0, 1.
        run_dump(5'd30, 5'd1, 1'b0);

        // Backpressure on a one-word dump of reg 5.
        regs_m[5] = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        first_reg = 5'd5;
        last_reg  = 5'd5;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_read_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        for (int c = 0; c < 7; c++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'hDEAD_BEEF);
            check("bp_addr", 32'(out_addr), 32'd5);
            check("bp_last", 32'(out_last), 32'd1);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_done", 32'(done), 32'd1);
        check("bp_done_busy", 32'(busy), 32'd1);
        check("bp_done_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_done", 32'(done), 32'd0);

        // Abort while addr 6 is presented in SEND.
        out_ready = 1'b1;
        first_reg = 5'd3;
        last_reg  = 5'd10;
        start     = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        budget = 0;
        dones  = 0;
        while (!(out_valid && out_addr == 5'd6) && budget < 100) begin
            if (done) dones++;
            @(negedge clock);
            budget++;
        end
        check("abort_reach6", 32'(out_valid && out_addr == 5'd6), 32'd1);
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        for (int c = 0; c < 3; c++) begin
            if (done) dones++;
            @(negedge clock);
        end
        check("abort_no_done", dones, 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);
        run_dump(5'd2, 5'd2, 1'b0);

        // Start pulse while busy must be ignored.
        run_dump(5'd8, 5'd9, 1'b1);

        // Asynchronous reset between edges while in SEND.
        out_ready = 1'b0;
        first_reg = 5'd12;
        last_reg  = 5'd20;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("ar_valid_before", 32'(out_valid), 32'd1);
        check("ar_addr_before", 32'(out_addr), 32'd12);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check_all_zero("async");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        check("ar_post_busy", 32'(busy), 32'd0);
        check("ar_post_valid", 32'(out_valid), 32'd0);
        run_dump(5'd1, 5'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32 x 32-bit CPU register file: on a start pulse it walks a programmable range of register addresses through one register-file read port, captures each value, and presents it with its address on a valid/ready output stream. It sits beside the register file, on the read side, and serves the debug/board-state path, for example streaming register contents to the GO-board display or host link without stalling the write port.

## Interface
Parameters:
- DATA_W, 32: register data width.
- ADDR_W, 5: register address width; range is 2**ADDR_W registers.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- ctrl_reset_n, in, 1: reset, asynchronous assert, active-low.
- start, in, 1: begin a dump; sampled only in IDLE.
- abort, in, 1: cancel a dump in progress.
- first_reg, in, ADDR_W: first address to dump; latched on accepted start.
- last_reg, in, ADDR_W: last address to dump; latched on accepted start.
- ctrl_readReg, out, ADDR_W: address driven to the register-file read port.
- data_readReg, in, DATA_W: combinational read data returned for ctrl_readReg.
- out_valid, out, 1: out_data/out_addr/out_last are valid.
- out_ready, in, 1: consumer accepts the word when out_valid && out_ready.
- out_data, out, DATA_W: captured register value.
- out_addr, out, ADDR_W: address of out_data.
- out_last, out, 1: high with the final word of the dump.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse after the final word is accepted.

## Operation
- FSM states are IDLE, READ, SEND and DONE.
- IDLE: if start is high, latch first_reg into cur_addr and last_reg into end_addr, then go to READ. While busy, start is ignored.
- READ: ctrl_readReg = cur_addr. At the edge, capture data_readReg into out_data, cur_addr into out_addr, and (cur_addr == end_addr) into out_last. Go to SEND.
- SEND: out_valid = 1.
  - On out_valid && out_ready with out_last = 1, go to DONE.
  - Otherwise, on acceptance, set cur_addr = cur_addr + 1 modulo 2**ADDR_W and go to READ.
  - Without out_ready, stay in SEND.
- DONE: done = 1 for one cycle, then go to IDLE.
- ctrl_readReg holds cur_addr in every state. In IDLE it holds the last value used.
- Word count is ((last_reg - first_reg) mod 2**ADDR_W) + 1.
  - first_reg == last_reg dumps exactly one word.
  - first_reg > last_reg wraps through 31 to 0.
- Register 0 is treated like any other address; its expected value is 0.
- abort, when high in READ, SEND or DONE, forces IDLE at the next edge. It has priority over every other transition. out_valid and out_last clear, and done is not pulsed. An abort in the same cycle as an accepted handshake still counts that word as transferred.
- abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- The block never drives the register-file write port. Writes landing during a dump are visible if they land before the corresponding READ cycle.

## Timing
- Reset (ctrl_reset_n low, asynchronous) gives: state IDLE, cur_addr = 0, end_addr = 0, ctrl_readReg = 0, out_valid = 0, out_data = 0, out_addr = 0, out_last = 0, busy = 0, done = 0. Reset mid-dump drops out_valid immediately, without waiting for a clock edge.
- Start accepted at edge N: busy is high after edge N, READ during cycle N+1, out_valid high after edge N+1.
- Maximum throughput is one word per 2 cycles, since READ and SEND alternate.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
  - out_valid never drops without acceptance, except on abort or reset.
- done is high for the cycle after the edge that accepts the last word. busy falls at the following edge.
- Minimum start-to-start interval for a one-word dump with out_ready tied high is 4 cycles.
- data_readReg is sampled only at the end of READ. Setup is the register-file combinational read path.

## Test plan
- Full dump: preload reg k = 0x1000_0000 + k, with reg0 = 0. Set first = 0, last = 31, out_ready = 1. Expect 32 words, addr 0..31, data 0x0000_0000 then 0x1000_0001..0x1000_001F. out_last only on addr 31, then a single done pulse.
- Wrap-around: first = 30, last = 1. Expect exactly 4 words at addresses 30, 31, 0, 1; out_last on addr 1.
- Backpressure: first = last = 5 with reg5 = 0xDEAD_BEEF. Hold out_ready = 0 for 7 cycles. out_valid, out_data = 0xDEAD_BEEF and out_addr = 5 stay stable. Raise out_ready: accepted, done the next cycle, busy low one edge later.
- Abort: start a dump of 3..10 and assert abort in SEND of addr 6. Next cycle: IDLE, out_valid = 0, busy = 0, no done pulse. A new start 2..2 then works normally.
- Start while busy: pulse start with first = 0 during an ongoing 8..9 dump. It is ignored, and the stream continues 8, 9.
- Async reset: drop ctrl_reset_n mid-SEND between clock edges. All outputs read 0 immediately, and after release the block sits in IDLE with busy = 0.
